// File: rtl/conversor_andar_histerese.sv
// conversor_andar_histerese: turns 3-digit BCD ultrasonic height samples (cm) into a
// debounced floor index. A floor change is committed only after N_AMOSTRAS consecutive
// agreeing samples fall outside the hysteresis band of the current floor.
// Stage 1 validates the BCD digits and registers the binary height. Stage 2 classifies
// the height and updates the floor FSM. Latency is 2 clocks, and a new sample can be
// accepted every cycle.
// Optional: define CONVERSOR_TIMEOUT_EN to drop validity after TIMEOUT_CICLOS idle clocks.
module conversor_andar_histerese #(
    parameter int unsigned N_ANDARES      = 4,
    parameter int unsigned W_ANDAR        = 2,
    parameter int unsigned ALTURA_ANDAR   = 10,
    parameter int unsigned HISTERESE_CM   = 2,
    parameter int unsigned N_AMOSTRAS     = 3,
    parameter int unsigned TIMEOUT_CICLOS = 1000000
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               medida_pronto_i,
    input  logic [3:0]         unidades_i,
    input  logic [3:0]         dezenas_i,
    input  logic [3:0]         centenas_i,
    output logic [W_ANDAR-1:0] andar_o,
    output logic               andar_valido_o,
    output logic               mudou_andar_o,
    output logic               fora_faixa_o,
    output logic               erro_bcd_o
);

    localparam int unsigned LIMITE = N_ANDARES * ALTURA_ANDAR;

    typedef enum logic [1:0] {StInicial, StEstavel, StConfirmando} estado_e;

    // ---------------- Stage 1: BCD check and conversion ----------------
    logic       digito_invalido;
    logic [9:0] altura_d, altura_q;
    logic       amostra_vld_q;
    logic       erro_bcd_q;

    // Flag bad digits and build the 10-bit binary height.
    always_comb begin
        digito_invalido = (unidades_i > 4'd9) || (dezenas_i > 4'd9) || (centenas_i > 4'd9);
        altura_d = 10'(centenas_i) * 10'd100 + 10'(dezenas_i) * 10'd10 + 10'(unidades_i);
    end

    // Register the height with a valid flag, or pulse erro_bcd when a sample is rejected.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            altura_q      <= '0;
            amostra_vld_q <= 1'b0;
            erro_bcd_q    <= 1'b0;
        end else begin
            amostra_vld_q <= medida_pronto_i && !digito_invalido;
            erro_bcd_q    <= medida_pronto_i && digito_invalido;
            if (medida_pronto_i && !digito_invalido) begin
                altura_q <= altura_d;
            end
        end
    end

    // ---------------- Stage 2: classification and floor FSM ----------------
    estado_e            estado_q;
    logic [W_ANDAR-1:0] andar_q;
    logic [W_ANDAR-1:0] cand_q;
    logic [3:0]         cnt_q;
    logic               valido_q;
    logic               mudou_q;
    logic               fora_q;

    logic [31:0]        altura_ext;
    logic [31:0]        base;
    logic [31:0]        banda_lo;
    logic [31:0]        banda_hi;
    logic               fora_d;
    logic               na_banda;
    logic [W_ANDAR-1:0] cand;
    logic [3:0]         cnt_prox;
    logic               confirma;
    logic               tmo_fim;

    // Range check, candidate floor (compare chain, no divider) and band test of current floor.
    always_comb begin
        altura_ext = 32'(altura_q);
        fora_d     = altura_ext >= LIMITE;
        cand       = '0;
        for (int unsigned k = 1; k < N_ANDARES; k++) begin
            if (altura_ext >= k * ALTURA_ANDAR) begin
                cand = W_ANDAR'(k);
            end
        end
        base     = 32'(andar_q) * ALTURA_ANDAR;
        // Lower band edge clamps at 0 for floor 0.
        banda_lo = (base > HISTERESE_CM) ? base - HISTERESE_CM : 32'd0;
        banda_hi = base + ALTURA_ANDAR + HISTERESE_CM;
        na_banda = (altura_ext >= banda_lo) && (altura_ext < banda_hi);
        // Leaving ESTAVEL always starts a fresh run of agreeing samples.
        if (estado_q == StEstavel) begin
            cnt_prox = 4'd1;
        end else if (cand == cand_q) begin
            cnt_prox = cnt_q + 4'd1;
        end else begin
            cnt_prox = 4'd1;
        end
        confirma = cnt_prox == 4'(N_AMOSTRAS);
    end

`ifdef CONVERSOR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);

    logic [TW-1:0] ocioso_q;

    // Idle-cycle counter: restarts on every strobe and saturates at the timeout.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            ocioso_q <= '0;
        end else if (medida_pronto_i) begin
            ocioso_q <= '0;
        end else if (ocioso_q != TW'(TIMEOUT_CICLOS)) begin
            ocioso_q <= ocioso_q + TW'(1);
        end
    end

    assign tmo_fim = !medida_pronto_i && (ocioso_q == TW'(TIMEOUT_CICLOS - 1));
`else
    assign tmo_fim = 1'b0;
`endif

    // Floor FSM with registered outputs; mudou_andar is a single-cycle commit pulse.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            estado_q <= StInicial;
            andar_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            valido_q <= 1'b0;
            mudou_q  <= 1'b0;
            fora_q   <= 1'b0;
        end else begin
            mudou_q <= 1'b0;
            if (amostra_vld_q) begin
                if (fora_d) begin
                    fora_q   <= 1'b1;
                    cnt_q    <= '0;
                    estado_q <= valido_q ? StEstavel : StInicial;
                end else begin
                    fora_q <= 1'b0;
                    if ((estado_q == StEstavel) && na_banda) begin
                        cnt_q <= '0;
                    end else if ((estado_q == StConfirmando) && na_banda) begin
                        cnt_q    <= '0;
                        estado_q <= StEstavel;
                    end else if (confirma) begin
                        andar_q  <= cand;
                        cand_q   <= cand;
                        valido_q <= 1'b1;
                        mudou_q  <= 1'b1;
                        cnt_q    <= '0;
                        estado_q <= StEstavel;
                    end else begin
                        cand_q   <= cand;
                        cnt_q    <= cnt_prox;
                        estado_q <= (estado_q == StInicial) ? StInicial : StConfirmando;
                    end
                end
            end
            // Timeout wins over any sample finishing in the same cycle; andar is held.
            if (tmo_fim) begin
                valido_q <= 1'b0;
                cnt_q    <= '0;
                estado_q <= StInicial;
            end
        end
    end

    assign andar_o        = andar_q;
    assign andar_valido_o = valido_q;
    assign mudou_andar_o  = mudou_q;
    assign fora_faixa_o   = fora_q;
    assign erro_bcd_o     = erro_bcd_q;

endmodule

// File: doc/conversor_andar_histerese.md
Name: conversor_andar_histerese

Overview:
- Sequential successor to the combinational BCD-height-to-floor converter in SmartCargo.
- Takes 3-digit BCD ultrasonic height samples (cm) and emits a debounced floor index for the elevator controller.
- Floor count, floor height, hysteresis band and confirmation count are parametrised.
- A floor change is committed only after N consecutive agreeing samples outside the current floor's hysteresis band.

Parameters:
- N_ANDARES, 4, number of floors (2..2^W_ANDAR).
- W_ANDAR, 2, width of floor index.
- ALTURA_ANDAR, 10, floor height in cm (1..99).
- HISTERESE_CM, 2, band extension in cm on each side of current floor (0..ALTURA_ANDAR-1).
- N_AMOSTRAS, 3, consecutive agreeing samples needed to commit (1..15).
- TIMEOUT_CICLOS, 1000000, clock cycles without a sample before validity drops (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- medida_pronto  in  1  one-cycle strobe; BCD digits valid this cycle.
- unidades  in  4  BCD units digit.
- dezenas  in  4  BCD tens digit.
- centenas  in  4  BCD hundreds digit.
- andar  out  W_ANDAR  committed floor.
- andar_valido  out  1  andar holds a committed value.
- mudou_andar  out  1  one-cycle pulse on every commit.
- fora_faixa  out  1  level; last accepted sample had altura >= N_ANDARES*ALTURA_ANDAR.
- erro_bcd  out  1  one-cycle pulse; sample rejected because a digit > 9.

Behaviour:
- Reset, synchronous while reset_n=0 at a clock edge: all outputs 0, state INICIAL, counter 0, pipeline flushed. Reset mid-confirmation discards the candidate.
- Stage 1, edge after the medida_pronto cycle:
  - Any digit > 9: sample dropped, erro_bcd pulses at this edge, no other effect.
  - Otherwise altura = centenas*100 + dezenas*10 + unidades, 10-bit unsigned, registered with a valid flag.
- Stage 2, next edge: classify and update. Total latency from medida_pronto to outputs is 2 clocks. Back-to-back strobes on every cycle are accepted, fully pipelined.
- Classification:
  - Out of range when altura >= N_ANDARES*ALTURA_ANDAR: fora_faixa<=1, counter<=0; state becomes ESTAVEL if andar_valido, else INICIAL; andar is held.
  - Any in-range sample sets fora_faixa<=0.
  - cand = altura / ALTURA_ANDAR, integer floor. Implement with a compare chain, no divider.
  - Band of floor k: [max(0, k*ALTURA_ANDAR - HISTERESE_CM), (k+1)*ALTURA_ANDAR + HISTERESE_CM).
- FSM:
  - INICIAL (no valid floor). In-range sample: if cand equals the stored candidate, cnt++; else store cand and set cnt=1. When cnt reaches N_AMOSTRAS: andar<=cand, andar_valido<=1, mudou_andar pulses, go to ESTAVEL, cnt<=0.
  - ESTAVEL. Sample inside the band of andar: stay. Sample outside the band: store cand, cnt=1, go to CONFIRMANDO. If N_AMOSTRAS=1, commit immediately instead.
  - CONFIRMANDO:
    - Sample inside the band of andar: cnt<=0, go to ESTAVEL.
    - Sample outside the band with the same cand: cnt++; commit when cnt reaches N_AMOSTRAS, then go to ESTAVEL.
    - Sample outside the band with a different cand: store it, cnt=1.
- Commit sets mudou_andar=1 for exactly one cycle, including the first commit from INICIAL.
- No medida_pronto means the state is held indefinitely, except as defined under the optional feature.

Optional Feature:
- CONVERSOR_TIMEOUT_EN defined:
  - A cycle counter restarts on every medida_pronto.
  - When it reaches TIMEOUT_CICLOS: andar_valido<=0, state INICIAL, cnt<=0. andar holds its last value; no mudou_andar pulse.
  - The next commit behaves as a first commit.
- CONVERSOR_TIMEOUT_EN undefined: no counter is instantiated, and validity never drops except on reset.

Test Plan:
- Reset, then 3 strobes of digits 0/1/5 (15 cm): after the 3rd strobe +2 clk, andar=1, andar_valido=1, mudou_andar high for 1 cycle; no pulse after 1st or 2nd.
- At floor 1, 5 strobes of 21 cm: andar stays 1, no pulse. Then 3 strobes of 23 cm: andar=2 with one pulse.
- At floor 1, sequence 23,21,23,23,23 cm: the 21 resets confirmation; commit to 2 only at the 5th sample.
- At floor 2, 45 cm: fora_faixa=1, andar=2 held. Then 3x 35 cm: andar=3, fora_faixa=0, one pulse.
- Units digit 4'hA with medida_pronto: erro_bcd pulses 1 clk later; andar, state and counter unchanged. Next valid sample is processed normally.
- Two samples of 23 cm at floor 1, then reset_n=0 for 1 clk: all outputs 0. With CONVERSOR_TIMEOUT_EN and TIMEOUT_CICLOS=50, 50 idle clocks after a commit: andar_valido=0, andar held.
